// File: rtl/nibble_seq_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  // Width of the nibble index for a given nibble count, never below one bit.
  function automatic int idx_width(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/fulladder4.sv
// 4-bit ripple adder slice, purely combinational.
module fulladder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_add_seq.sv
// Multi-cycle WIDTH-bit adder sharing one fulladder4 slice, LSB nibble first.
// Optional subtract support is enabled with the NIBBLE_SUB_EN macro.
module nibble_add_seq
  import nibble_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = idx_width(NIB);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, b_reg, res_reg, res_next;
  logic               carry_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               last_nib;
  logic [NIB_W-1:0]   slice_a, slice_b, slice_s;
  logic               slice_cout;
  logic [WIDTH-1:0]   b_eff;
  logic               cin_eff;

`ifdef NIBBLE_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign last_nib = (idx_reg == IDX_W'(NIB - 1));

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        slice_a = a_reg[NIB_W*i +: NIB_W];
        slice_b = b_reg[NIB_W*i +: NIB_W];
      end
    end
  end

  fulladder4 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Result register with the current nibble merged in.
  for (genvar gi = 0; gi < NIB; gi++) begin : g_res
    assign res_next[NIB_W*gi +: NIB_W] =
      (idx_reg == IDX_W'(gi)) ? slice_s : res_reg[NIB_W*gi +: NIB_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last_nib) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are loaded on the final RUN edge so they are valid throughout DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b_eff;
            carry_reg <= cin_eff;
            idx_reg   <= '0;
          end
        end
        ST_RUN: begin
          res_reg   <= res_next;
          carry_reg <= slice_cout;
          idx_reg   <= idx_reg + IDX_W'(1);
          if (last_nib) begin
            sum  <= res_next;
            cout <= slice_cout;
            ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                    (res_next[WIDTH-1] != a_reg[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
